// File: rtl/prod_accum.sv
// prod_accum: frame accumulator behind the 32-bit multiplier.
// Sums LEN unsigned products per frame into an ACC_W-bit total. The total is
// presented on a valid/ready output together with a sticky per-frame
// overflow flag.
// Optional build macro PROD_ACCUM_SAT_EN: clamp the sum at 2^ACC_W-1 on
// overflow instead of wrapping.
module prod_accum #(
    parameter int W     = 32,
    parameter int ACC_W = 40,
    parameter int LEN   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf
);

    localparam int CNT_W = $clog2(LEN + 1);

    typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [ACC_W-1:0]   out_data_q, out_data_d;
    logic               out_ovf_q, out_ovf_d;

    logic               accept;
    logic               last;
    logic [ACC_W:0]     sum;
    logic               carry;
    logic [ACC_W-1:0]   acc_nx;
    logic               ovf_nx;

    assign accept = in_valid & in_ready;
    assign last   = (cnt_q == CNT_W'(LEN - 1));
    assign sum    = {1'b0, acc_q} + {{(ACC_W + 1 - W){1'b0}}, in_data};
    assign carry  = sum[ACC_W];
    assign ovf_nx = ovf_q | carry;

`ifdef PROD_ACCUM_SAT_EN
    // Once clamped, acc sits at all-ones, so any later nonzero add carries
    // again and keeps it clamped.
    assign acc_nx = carry ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
    assign acc_nx = sum[ACC_W-1:0];
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ACCUM;
        else     state_q <= state_d;
    end

    // Next-state logic; clr overrides everything
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = ACCUM;
        end else begin
            case (state_q)
                ACCUM:   if (accept && last) state_d = HOLD;
                HOLD:    if (out_ready)      state_d = ACCUM;
                default: state_d = ACCUM;
            endcase
        end
    end

    // Handshake outputs depend on state only
    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == HOLD);
    end

    // Datapath next values: partial sum, count, sticky overflow, result
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        out_data_d = out_data_q;
        out_ovf_d  = out_ovf_q;
        if (clr) begin
            acc_d = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (accept) begin
            if (last) begin
                out_data_d = acc_nx;
                out_ovf_d  = ovf_nx;
                acc_d      = '0;
                cnt_d      = '0;
                ovf_d      = 1'b0;
            end else begin
                acc_d = acc_nx;
                cnt_d = cnt_q + 1'b1;
                ovf_d = ovf_nx;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            out_data_q <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            out_data_q <= out_data_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    assign out_data = out_data_q;
    assign out_ovf  = out_ovf_q;

endmodule

// File: tb/tb_prod_accum.sv
// Bench for prod_accum (W=32, ACC_W=32, LEN=4). Directed scenarios plus
// randomized frames checked against a frame-sum reference model.
module tb_prod_accum;

    localparam int W     = 32;
    localparam int ACC_W = 32;
    localparam int LEN   = 4;
    localparam longint unsigned MAXV = (64'd1 << ACC_W) - 64'd1;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic             out_ovf;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    prod_accum #(.W(W), .ACC_W(ACC_W), .LEN(LEN)) dut (
        .clk(clk), .rst(rst), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ovf(out_ovf)
    );

    // Reference: the true (unbounded) frame total decides both outputs.
    // A carry happened during the frame iff the total exceeds 2^ACC_W-1.
    function automatic logic [ACC_W-1:0] exp_data(input longint unsigned tot);
`ifdef PROD_ACCUM_SAT_EN
        if (tot > MAXV) return ACC_W'(MAXV);
`endif
        return ACC_W'(tot & MAXV);
    endfunction

    function automatic logic exp_ovf(input longint unsigned tot);
        return tot > MAXV;
    endfunction

    // All drivers start and end at a negedge. One product, accepted at the
    // posedge in between.
    task automatic send(input logic [W-1:0] d);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait (bounded) for a result, capture it, then complete the handshake.
    task automatic take(output logic [ACC_W-1:0] d, output logic o);
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            tests++; fails++;
            $display("FAIL take_timeout: out_valid=%0b required 1", out_valid);
        end
        d = out_data;
        o = out_ovf;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== '0 || out_ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_vals: rdy=%b vld=%b data=%h ovf=%b required 1 0 0 0",
                     in_ready, out_valid, out_data, out_ovf);
        end
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL post_reset: rdy=%b vld=%b required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(1); send(2); send(3);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL basic_early: out_valid=%b required 0", out_valid);
        end
        send(4);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'd10 || out_ovf !== 1'b0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL basic_result: vld=%b data=%0d ovf=%b rdy=%b required 1 10 0 0",
                     out_valid, out_data, out_ovf, in_ready);
        end
        @(negedge clk);
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL basic_after: vld=%b rdy=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        repeat (LEN) send(5);
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (out_valid !== 1'b1 || out_data !== 32'd20 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold[%0d]: vld=%b data=%0d rdy=%b required 1 20 0",
                         i, out_valid, out_data, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release: vld=%b rdy=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_overflow();
        logic [ACC_W-1:0] d;
        logic o;
        send(32'hFFFF_FFFF); send(32'h2); send(32'h0); send(32'h0);
        take(d, o);
        tests++;
        if (d !== exp_data(64'h1_0000_0001) || o !== 1'b1) begin
            fails++;
            $display("FAIL overflow: data=%h ovf=%b required %h 1", d, o, exp_data(64'h1_0000_0001));
        end
        // Next frame must start with the sticky flag cleared
        repeat (LEN) send(32'h1);
        take(d, o);
        tests++;
        if (d !== 32'd4 || o !== 1'b0) begin
            fails++; $display("FAIL ovf_cleared: data=%0d ovf=%b required 4 0", d, o);
        end
    endtask

    task automatic test_clr();
        logic [ACC_W-1:0] d;
        logic o;
        send(7); send(7);
        clr = 1'b1; in_valid = 1'b1; in_data = 9;
        @(negedge clk);
        clr = 1'b0; in_valid = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL clr_state: rdy=%b vld=%b required 1 0", in_ready, out_valid);
        end
        repeat (LEN) send(1);
        take(d, o);
        tests++;
        if (d !== 32'd4 || o !== 1'b0) begin
            fails++; $display("FAIL clr_frame: data=%0d ovf=%b required 4 0", d, o);
        end
        // clr while holding a result drops it
        repeat (LEN) send(3);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++; $display("FAIL clr_hold: vld=%b rdy=%b required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_async_reset_hold();
        logic [ACC_W-1:0] d;
        logic o;
        send(3); send(3); send(3); send(3);
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'd12) begin
            fails++; $display("FAIL rst_pre: vld=%b data=%0d required 1 12", out_valid, out_data);
        end
        #2 rst = 1'b1;
        #1;
        tests++;
        if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL rst_async: vld=%b data=%h rdy=%b required 0 0 1", out_valid, out_data, in_ready);
        end
        #1 rst = 1'b0;
        @(negedge clk);
        send(2); send(2); send(0); send(0);
        take(d, o);
        tests++;
        if (d !== 32'd4 || o !== 1'b0) begin
            fails++; $display("FAIL rst_next: data=%0d ovf=%b required 4 0", d, o);
        end
    endtask

    task automatic test_gaps();
        logic [ACC_W-1:0] d;
        logic o;
        send(10);
        repeat (3) @(negedge clk);
        send(20); send(30);
        tests++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL gaps_early: vld=%b required 0", out_valid);
        end
        send(0);
        take(d, o);
        tests++;
        if (d !== 32'd60 || o !== 1'b0) begin
            fails++; $display("FAIL gaps: data=%0d ovf=%b required 60 0", d, o);
        end
    endtask

    task automatic test_random();
        logic [ACC_W-1:0] d;
        logic o;
        logic [W-1:0] p;
        longint unsigned tot;
        for (int f = 0; f < 40; f++) begin
            tot = 0;
            for (int k = 0; k < LEN; k++) begin
                p = ($urandom_range(0, 1) == 0) ? W'($urandom) : W'($urandom_range(0, 1000));
                tot += longint'(p);
                repeat ($urandom_range(0, 2)) @(negedge clk);
                send(p);
            end
            repeat ($urandom_range(0, 3)) begin
                tests++;
                if (out_valid !== 1'b1 || out_data !== exp_data(tot) || in_ready !== 1'b0) begin
                    fails++;
                    $display("FAIL rand_hold[%0d]: vld=%b data=%h rdy=%b required 1 %h 0",
                             f, out_valid, out_data, in_ready, exp_data(tot));
                end
                @(negedge clk);
            end
            take(d, o);
            tests++;
            if (d !== exp_data(tot) || o !== exp_ovf(tot)) begin
                fails++;
                $display("FAIL rand_frame[%0d]: data=%h ovf=%b required %h %b",
                         f, d, o, exp_data(tot), exp_ovf(tot));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overflow();
        test_clr();
        test_async_reset_hold();
        test_gaps();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/prod_accum.md
# prod_accum

Frame accumulator that sits directly downstream of the 32-bit combinational multiplier. It consumes a stream of unsigned products over a valid/ready handshake and sums each frame of LEN products into an ACC_W-bit total. It presents one result per frame on a valid/ready output with a per-frame overflow flag. It is the multiply-accumulate back end for dot-product style use of the multiplier.

## Interface
- W, 32, product (input) width; must be ≥ 1
- ACC_W, 40, accumulator/output width; must be ≥ W
- LEN, 8, products per frame; must be ≥ 1
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- clr  input  1  synchronous frame abort: discards partial sum and any pending result
- in_valid  input  1  product on in_data is valid
- in_ready  output  1  block accepts a product this cycle
- in_data  input  W  unsigned product
- out_valid  output  1  frame result available
- out_ready  input  1  consumer takes result this cycle
- out_data  output  ACC_W  frame sum
- out_ovf  output  1  frame sum exceeded ACC_W bits (valid with out_valid)

## Operation
- States: ACCUM, HOLD.
- **ACCUM**
  - in_ready=1, out_valid=0.
  - On accept (in_valid & in_ready): acc ← acc + zero-extended in_data; cnt ← cnt+1.
  - Carry out of ACC_W sets the sticky ovf flag for the frame.
  - Accept with cnt==LEN-1: registers the final sum into out_data and ovf into out_ovf. acc←0, cnt←0, ovf←0, state→HOLD.
- **HOLD**
  - in_ready=0, out_valid=1; out_data and out_ovf are stable.
  - out_valid & out_ready: out_valid←0, state→ACCUM.
- **clr** (highest priority, any state)
  - acc←0, cnt←0, ovf←0, out_valid←0, state→ACCUM.
  - A product presented in the same cycle is not counted.
  - A pending HOLD result is dropped.
- **Arithmetic**
  - Unsigned, modulo 2^ACC_W unless saturation is compiled in (see Configuration).
  - cnt width is $clog2(LEN+1).
  - LEN=1: every accepted product goes straight to HOLD.
- **Reset mid-frame:** partial sum is lost; no output is produced for that frame.

## Timing
- **Reset values:** state=ACCUM, in_ready=1, out_valid=0, out_data=0, out_ovf=0; internal acc, cnt and ovf = 0.
- in_ready is a function of state only; it never depends on in_valid.
- **Latency:** out_valid rises the cycle after the LEN-th accept.
- **Throughput:** LEN accepts + 1 handshake cycle minimum per frame. No overlap: in_ready=0 for the whole of HOLD, including the out_ready cycle. in_ready returns to 1 the cycle after the output handshake.
- **Backpressure:** out_valid, out_data and out_ovf hold unchanged while out_ready=0, for any duration.
- in_valid gaps do not disturb the partial sum or cnt.

## Configuration
- Macro: PROD_ACCUM_SAT_EN.
- **Defined:** on any carry out of ACC_W, acc clamps to 2^ACC_W−1 and stays clamped for the rest of the frame; ovf=1.
- **Undefined:** acc wraps modulo 2^ACC_W; ovf=1 on any carry during the frame.
- out_ovf behaviour is identical in both builds; only out_data differs.

## Test plan
- **Basic frame** (LEN=4, out_ready=1): accept 1,2,3,4 → one cycle after the 4th accept, out_valid=1, out_data=10, out_ovf=0. in_ready=0 that cycle and 1 the next.
- **Backpressure** (LEN=4): frame 5,5,5,5 with out_ready=0 for 6 cycles → out_valid=1 and out_data=20 held all 6 cycles, in_ready=0 throughout. Raise out_ready → out_valid=0 the next cycle.
- **Overflow** (W=ACC_W=32, LEN=2): accept 0xFFFFFFFF, 0x2 → without macro out_data=0x1, out_ovf=1. With PROD_ACCUM_SAT_EN, out_data=0xFFFFFFFF, out_ovf=1.
- **clr mid-frame** (LEN=4): accept 7,7; assert clr together with in_valid (data 9); then accept 1,1,1,1 → out_data=4, out_ovf=0.
- **Async reset in HOLD** (LEN=2): accept 3,3 so out_valid=1; pulse rst between clock edges → out_valid=0 and out_data=0 immediately. Next frame 2,2 gives out_data=4.
- **Valid gaps** (LEN=3): accept 10, idle 3 cycles, then 20, 30 → out_data=60.
